// File: rtl/mem_access_if.sv
// Data-side SRAM-like bus between the memory access unit (master) and memory (slave).
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: lane steering, strobes, load extension and pipeline stall.
// Define MEM_ADDR_EXC_EN to trap misaligned half/word accesses (adelM/adesM) instead of aligning them.
module mem_access_unit #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RDATA_RESET = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [1:0]        memsizeM,
  input  logic              memsignedM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [31:0]       writedataM,
  output logic [31:0]       readdataM,
  output logic              stallM,
`ifdef MEM_ADDR_EXC_EN
  output logic              adelM,
  output logic              adesM,
`endif
  mem_access_if.master      bus
);
  typedef enum logic [1:0] {IDLE, DATA, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] readdata_q, readdata_d;
  logic [1:0]  size_w, a;
  logic        misalign, req_c, complete;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;

  assign size_w = (memsizeM == 2'd3) ? 2'd2 : memsizeM;
  assign a      = aluoutM[1:0];

`ifdef MEM_ADDR_EXC_EN
  logic adel_q, adel_d, ades_q, ades_d;
  assign misalign = ((size_w == 2'd1) && a[0]) || ((size_w == 2'd2) && (a != 2'd0));
  assign adelM    = adel_q;
  assign adesM    = ades_q;
`else
  assign misalign = 1'b0;
`endif

  // Lane steering always uses the naturally aligned lane of the access size.
  always_comb begin
    bus.data_wdata = writedataM;
    bus.data_wstrb = 4'b1111;
    case (size_w)
      2'd0: begin
        bus.data_wdata = {4{writedataM[7:0]}};
        bus.data_wstrb = 4'b0001 << a;
      end
      2'd1: begin
        bus.data_wdata = {2{writedataM[15:0]}};
        bus.data_wstrb = 4'b0011 << {a[1], 1'b0};
      end
      default: ;
    endcase
    if (!memwriteM) bus.data_wstrb = 4'b0000;
  end

  assign bus.data_wr   = memwriteM;
  assign bus.data_size = size_w;
  assign bus.data_addr = aluoutM;
  assign bus.data_req  = req_c;

  always_comb begin
    lb  = bus.data_rdata[{a, 3'b000} +: 8];
    lh  = a[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    ext = bus.data_rdata;
    case (size_w)
      2'd0:    ext = {{24{memsignedM & lb[7]}}, lb};
      2'd1:    ext = {{16{memsignedM & lh[15]}}, lh};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    readdata_d = readdata_q;
    req_c      = 1'b0;
    complete   = 1'b0;
    case (state_q)
      IDLE: if (memenM) begin
        if (misalign) begin
          state_d = DONE;
        end else begin
          req_c = 1'b1;
          // data_ok without the address handshake is stale and must not complete us.
          if (bus.data_addr_ok) begin
            if (bus.data_data_ok) begin
              state_d  = DONE;
              complete = 1'b1;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: if (bus.data_data_ok) begin
        state_d  = DONE;
        complete = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (complete && !memwriteM) readdata_d = ext;
  end

`ifdef MEM_ADDR_EXC_EN
  always_comb begin
    adel_d = (state_q == IDLE) && memenM && misalign && !memwriteM;
    ades_d = (state_q == IDLE) && memenM && misalign &&  memwriteM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel_q <= 1'b0;
      ades_q <= 1'b0;
    end else begin
      adel_q <= adel_d;
      ades_q <= ades_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      readdata_q <= RDATA_RESET;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdataM = readdata_q;
  assign stallM    = memenM && (state_q != DONE);
endmodule
